// File: rtl/rtr_ingress_arbiter.sv
// Round-robin ingress arbiter: grants one of N_REQ packet sources, serializes its
// 6-bit packet MSB-first with ser_valid framing, then idles GAP cycles.
module rtr_ingress_arbiter #(
  parameter int N_REQ = 4,
  parameter int PKT_W = 6,
  parameter int GAP   = 2,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*PKT_W-1:0]     pkt_in,
  output logic [N_REQ-1:0]           gnt,
  output logic                       ser_out,
  output logic                       ser_valid,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(N_REQ)-1:0]   last_id,
  output logic [CNT_W-1:0]           sent_cnt
);
  localparam int IW = $clog2(N_REQ);
  localparam int BW = $clog2(PKT_W);
  localparam int GW = $clog2(GAP + 2);
  localparam int unsigned NU = N_REQ;

  if (N_REQ < 2 || N_REQ > 8 || PKT_W != 6 || GAP < 1) begin : g_bad_param
    $error("rtr_ingress_arbiter: invalid N_REQ, PKT_W or GAP");
  end

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  state_t             r_state, w_state;
  logic [PKT_W-1:0]   r_shift, w_shift;
  logic [BW-1:0]      r_bit, w_bit;
  logic [GW-1:0]      r_gap, w_gap;
  logic [IW-1:0]      r_last, w_last;
  logic [CNT_W-1:0]   r_cnt, w_cnt;
  logic [N_REQ-1:0]   r_gnt, w_gnt;
  logic               r_ser_out, w_ser_out;
  logic               r_ser_valid, w_ser_valid;
  logic               r_busy, w_busy;
  logic               r_done, w_done;
  logic               w_found;
  logic [IW-1:0]      w_sel;
  logic [PKT_W-1:0]   w_pkt;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    int unsigned v_k;
    w_found = 1'b0;
    w_sel   = '0;
    v_k     = 0;
    for (int unsigned i = 1; i <= NU; i++) begin
      v_k = (32'(r_last) + i) % NU;
      if (!w_found && req[v_k]) begin
        w_found = 1'b1;
        w_sel   = IW'(v_k);
      end
    end
    w_pkt = pkt_in[w_sel*PKT_W +: PKT_W];
  end

  always_comb begin
    w_state     = r_state;
    w_shift     = r_shift;
    w_bit       = r_bit;
    w_gap       = r_gap;
    w_last      = r_last;
    w_cnt       = r_cnt;
    w_gnt       = '0;
    w_ser_out   = 1'b0;
    w_ser_valid = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable && w_found) begin
          w_state     = S_SEND;
          w_shift     = w_pkt;
          w_bit       = '0;
          w_last      = w_sel;
          w_gnt       = N_REQ'(1) << w_sel;
          w_ser_out   = w_pkt[PKT_W-1];
          w_ser_valid = 1'b1;
          w_busy      = 1'b1;
        end
      end
      S_SEND: begin
        w_busy = 1'b1;
        if (r_bit == BW'(PKT_W - 1)) begin
          w_state = S_GAP;
          w_gap   = '0;
          w_done  = 1'b1;
          w_cnt   = r_cnt + 1'b1;
        end else begin
          w_bit       = r_bit + 1'b1;
          w_shift     = {r_shift[PKT_W-2:0], 1'b0};
          w_ser_out   = r_shift[PKT_W-2];
          w_ser_valid = 1'b1;
        end
      end
      S_GAP: begin
        if (r_gap == GW'(GAP - 1)) begin
          w_state = S_IDLE;
        end else begin
          w_gap  = r_gap + 1'b1;
          w_busy = 1'b1;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_bit       <= '0;
      r_gap       <= '0;
      r_last      <= IW'(N_REQ - 1);
      r_cnt       <= '0;
      r_gnt       <= '0;
      r_ser_out   <= 1'b0;
      r_ser_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_shift     <= w_shift;
      r_bit       <= w_bit;
      r_gap       <= w_gap;
      r_last      <= w_last;
      r_cnt       <= w_cnt;
      r_gnt       <= w_gnt;
      r_ser_out   <= w_ser_out;
      r_ser_valid <= w_ser_valid;
      r_busy      <= w_busy;
      r_done      <= w_done;
    end
  end

  assign gnt       = r_gnt;
  assign ser_out   = r_ser_out;
  assign ser_valid = r_ser_valid;
  assign busy      = r_busy;
  assign done      = r_done;
  assign last_id   = r_last;
  assign sent_cnt  = r_cnt;

endmodule

// File: doc/rtr_ingress_arbiter.md
Name: rtr_ingress_arbiter

Overview:
- Shares the single serial ingress of the simple router (`in` / `rx_ready`) between N_REQ parallel packet sources.
- Each source presents a 6-bit packet: bits [5:4] are the destination port, bits [3:0] are the payload.
- The block arbitrates round-robin, serializes the granted packet MSB-first with rx_ready framing, then inserts an idle gap so the router sees rx_ready low and emits the packet on dst/tx_ready.
- Sits directly upstream of the router, clocked by the same clk.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- PKT_W, 6, packet width; fixed at 6 to match the router framing.
- GAP, 2, idle cycles (ser_valid low) after each packet; must be >= 1.
- CNT_W, 16, width of the sent-packet counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  when low, no new grants; an in-flight packet completes.
- req  input  N_REQ  per-requester request level.
- pkt_in  input  N_REQ*PKT_W  packet of requester k at bits [k*PKT_W +: PKT_W].
- gnt  output  N_REQ  one-hot, one-cycle grant pulse; the packet was captured on the preceding edge.
- ser_out  output  1  serial data to router `in`.
- ser_valid  output  1  framing to router `rx_ready`.
- busy  output  1  high in SEND and GAP states.
- done  output  1  one-cycle pulse in the first GAP cycle.
- last_id  output  $clog2(N_REQ)  index of the most recently granted requester.
- sent_cnt  output  CNT_W  packets fully serialized; wraps modulo 2^CNT_W.

Behaviour:
- Reset (asynchronous, effective immediately, mid-packet included):
  - state = IDLE; gnt = 0, ser_out = 0, ser_valid = 0, busy = 0, done = 0.
  - last_id = N_REQ-1, so requester 0 has first priority.
  - sent_cnt = 0; shift register and counters cleared.
  - A truncated packet is not retransmitted. The router discards it because it sees fewer than 6 bits.
- FSM states: IDLE, SEND, GAP.
- IDLE:
  - If enable && |req at edge T: select the first requester with req set, searching last_id+1, last_id+2, ... modulo N_REQ.
  - On edge T: latch its packet into a 6-bit shift register, set last_id to its index, go to SEND with bit counter = 0.
  - gnt[k] is high for exactly cycle T+1. The requester may then change pkt_in or drop req; the latched copy is used.
  - Otherwise stay in IDLE with all outputs low.
- SEND, cycles T+1..T+6:
  - ser_valid = 1, busy = 1.
  - ser_out = pkt[5] in T+1, pkt[4] in T+2, ... pkt[0] in T+6, so the router's data[5:4] holds the address after 6 shifts.
  - After the 6th bit go to GAP.
- GAP, cycles T+7..T+6+GAP:
  - ser_valid = 0, ser_out = 0, busy = 1.
  - done = 1 in cycle T+7 only; sent_cnt increments at entry to GAP (visible from T+7).
  - After GAP cycles go to IDLE. IDLE is combinationally ready, so the earliest next grant edge is the end of the first IDLE cycle.
  - Minimum packet-to-packet period = 7 + GAP cycles.
- req arriving while busy is held pending; it is evaluated only in IDLE. A req dropped before its grant is not served.
- enable low during SEND/GAP has no effect on the current packet; it blocks the next grant only.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,...,N_REQ-1,0,...; each is served exactly once per N_REQ packets.
- Single requester: served back-to-back at the minimum period.
- Outputs gnt, ser_out, ser_valid, done and busy are registered; no combinational path from req/pkt_in to any output.
- Invalid N_REQ or GAP: elaboration error.

Test Plan:
- Reset, then req=4'b0001 with pkt_in[5:0]=6'b10_1011 -> gnt=0001 one cycle; ser_out 1,0,1,0,1,1 with ser_valid high 6 cycles; done next cycle; router drives dst[2]=4'hB, tx_ready=4'b0100; sent_cnt=1.
- req=4'b1111 held for 8 packets, GAP=2 -> grant order 0,1,2,3,0,1,2,3; grant edges exactly 9 cycles apart; sent_cnt=8.
- last_id=1, then req=4'b1001 -> requester 3 granted first, requester 0 next.
- Assert rst in the 3rd SEND cycle -> ser_valid and busy go low before the next edge; sent_cnt=0; router emits nothing; next grant goes to requester 0.
- enable=0 with req=4'b0010 -> no gnt for 20 cycles. Raise enable -> gnt=0010 on the following cycle. Drop enable mid-SEND -> packet completes and done pulses.
- Requester changes pkt_in in the cycle after gnt -> the serialized bits match the value latched at the grant edge.
